game_session_controller: RTL and testbench
==========================================

# game_session_controller

Session-level controller for the reaction-time game. It sequences a timed game session, runs the seconds countdown, keeps score and level, and sets the response window used by the per-round reaction FSM. It sits above the reaction FSM and the millisecond timer: it resets the FSM at session start, gates its game timer, and consumes its hit/miss pulses.

## Interface
Parameters:
- GAME_SECONDS, 30: session length in seconds; must be 1..63.
- HITS_PER_LEVEL, 5: hits needed to advance one level.
- MAX_LEVEL, 9: level saturation value; must be ≤ 15.
- BASE_WINDOW_MS, 1000: response window at level 1.
- WINDOW_STEP_MS, 100: window reduction per level above 1.
- MIN_WINDOW_MS, 200: window floor.
- MAX_MS, 2047: timer ceiling; all window values must be ≤ MAX_MS.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- ms_tick  in  1  one-cycle pulse once per millisecond.
- start_edge  in  1  one-cycle button-edge pulse that starts or restarts a session.
- hit  in  1  one-cycle pulse from the reaction FSM for a correct response.
- miss  in  1  one-cycle pulse from the reaction FSM for a wrong or late response.
- game_reset  out  1  one-cycle pulse that clears the reaction FSM at session start.
- game_timer_enable  out  1  high while a session is in play.
- game_timer_value  out  6  seconds remaining.
- user_score  out  7  hits this session; saturates at 99.
- level  out  4  current level, 1..MAX_LEVEL.
- window_ms  out  11  response window for the reaction FSM.
- game_over  out  1  high once the session has expired.

## Operation
- State machine: IDLE, ARM, PLAY, OVER.
  - IDLE → ARM on start_edge.
  - ARM → PLAY unconditionally after one cycle.
  - PLAY → OVER when the seconds countdown expires.
  - OVER → ARM on start_edge.
  - start_edge is ignored in ARM and in PLAY.
- ARM actions:
  - game_reset = 1 for exactly this one cycle.
  - score cleared to 0, level set to 1, hit-in-level counter cleared.
  - seconds loaded with GAME_SECONDS; millisecond counter cleared.
- Countdown (PLAY only):
  - A 10-bit millisecond counter counts ms_tick from 0 to 999.
  - On the tick that takes it from 999 to 0, seconds decrements.
  - If that decrement takes seconds from 1 to 0, the state goes to OVER on the same edge.
- Score and level:
  - hit in PLAY: score += 1, saturating at 99; the hit-in-level counter increments.
  - When the counter would reach HITS_PER_LEVEL, it clears and level += 1, saturating at MAX_LEVEL. The counter still clears at MAX_LEVEL.
  - hit and miss outside PLAY are ignored.
  - hit and miss in the same cycle: hit is taken, miss is ignored.
- Window:
  - window_ms = max(MIN_WINDOW_MS, BASE_WINDOW_MS − (level−1)·WINDOW_STEP_MS).
  - The subtraction is evaluated in at least 16 bits so it cannot underflow before the floor is applied.
- Output decode:
  - game_timer_enable = (state == PLAY).
  - game_over = (state == OVER).
  - game_timer_value = seconds register.
- Simultaneous events: a hit on the same cycle as the final expiry tick is counted, and the state still goes to OVER.

## Timing
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs.
- Reset values:
  - state IDLE, game_reset 0, game_timer_enable 0, game_over 0.
  - game_timer_value = GAME_SECONDS, user_score 0, level 1.
  - window_ms = BASE_WINDOW_MS, millisecond counter 0.
- Start latency: start_edge sampled at edge N gives ARM and game_reset = 1 during cycle N+1, then PLAY and game_timer_enable = 1 from N+2.
- hit sampled at edge N: user_score and level update at edge N; window_ms updates at edge N+1, one cycle after level.
- ms_tick pulses arriving in IDLE, ARM or OVER are ignored; the millisecond counter holds.
- reset mid-session: returns to IDLE with the reset values on the next edge; no game_reset pulse is issued.

## Configuration
- GAME_PENALTY_EN defined:
  - miss in PLAY decrements score, saturating at 0.
  - miss also clears the hit-in-level counter.
  - Level never decreases.
- GAME_PENALTY_EN undefined: miss has no effect on any state.

## Test plan
- Reset asserted for 3 cycles → IDLE, user_score 0, level 1, window_ms 1000, game_timer_value 30, game_timer_enable 0, game_over 0.
- start_edge pulse → game_reset high for exactly 1 cycle, game_timer_enable high from the following cycle; a second start_edge during PLAY causes no further game_reset.
- 5 hit pulses in PLAY → user_score 5, level 2, window_ms 900 one cycle after level; 40 hits → level saturates at 9, window_ms 200.
- GAME_SECONDS = 2, drive 1000 ms_ticks → game_timer_value 1; 1000 more → game_timer_value 0, game_over 1, game_timer_enable 0; a later hit leaves the score unchanged.
- hit coincident with the final expiry tick → user_score increments by 1 and the state is OVER on the same edge.
- With GAME_PENALTY_EN: miss at score 3 → 2, miss at score 0 → stays 0. Without the macro: miss at score 3 → stays 3. With or without: hit+miss in one cycle → score +1.

Source files
------------

// File: rtl/game_session_controller.sv
// game_session_controller: session sequencer for the reaction-time game.
// Runs the IDLE/ARM/PLAY/OVER session FSM, the seconds countdown, score and level
// tracking, and derives the response window handed to the per-round reaction FSM.
// Optional feature: define GAME_PENALTY_EN so that a miss in play costs one point
// and restarts progress toward the next level.
module game_session_controller #(
    parameter int unsigned GAME_SECONDS   = 30,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned MAX_LEVEL      = 9,
    parameter int unsigned BASE_WINDOW_MS = 1000,
    parameter int unsigned WINDOW_STEP_MS = 100,
    parameter int unsigned MIN_WINDOW_MS  = 200,
    parameter int unsigned MAX_MS         = 2047
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_tick,
    input  logic        start_edge,
    input  logic        hit,
    input  logic        miss,
    output logic        game_reset,
    output logic        game_timer_enable,
    output logic [5:0]  game_timer_value,
    output logic [6:0]  user_score,
    output logic [3:0]  level,
    output logic [10:0] window_ms,
    output logic        game_over
);

    localparam int unsigned SEC_W     = 6;
    localparam int unsigned SCORE_W   = 7;
    localparam int unsigned LVL_W     = 4;
    localparam int unsigned WIN_W     = 11;
    localparam int unsigned MS_W      = 10;
    localparam int unsigned HIT_W     = (HITS_PER_LEVEL < 2) ? 1 : $clog2(HITS_PER_LEVEL + 1);
    localparam int unsigned SCORE_MAX = 99;
    localparam int unsigned MS_LAST   = 999;

    typedef enum logic [1:0] {IDLE, ARM, PLAY, OVER} state_t;

    state_t             state_q, state_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [SCORE_W-1:0] score_d;
    logic [LVL_W-1:0]   level_d;
    logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [WIN_W-1:0]   window_d;
    int                 win_raw;

    assign game_timer_value = sec_q;

`ifndef GAME_PENALTY_EN
    logic unused_miss;
    assign unused_miss = miss;
`endif

    // Session state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state, countdown, score and level update.
    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        ms_d      = ms_q;
        score_d   = user_score;
        level_d   = level;
        hit_cnt_d = hit_cnt_q;
        unique case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_d   = ARM;
                    sec_d     = SEC_W'(GAME_SECONDS);
                    ms_d      = '0;
                    score_d   = '0;
                    level_d   = LVL_W'(1);
                    hit_cnt_d = '0;
                end
            end
            ARM: state_d = PLAY;
            PLAY: begin
                if (ms_tick) begin
                    if (ms_q == MS_W'(MS_LAST)) begin
                        ms_d  = '0;
                        sec_d = sec_q - SEC_W'(1);
                        if (sec_q == SEC_W'(1)) state_d = OVER;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end
                if (hit) begin
                    if (user_score != SCORE_W'(SCORE_MAX)) score_d = user_score + SCORE_W'(1);
                    if (hit_cnt_q == HIT_W'(HITS_PER_LEVEL - 1)) begin
                        hit_cnt_d = '0;
                        if (level != LVL_W'(MAX_LEVEL)) level_d = level + LVL_W'(1);
                    end else begin
                        hit_cnt_d = hit_cnt_q + HIT_W'(1);
                    end
                end
`ifdef GAME_PENALTY_EN
                else if (miss) begin
                    if (user_score != '0) score_d = user_score - SCORE_W'(1);
                    hit_cnt_d = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Window from the registered level, evaluated wide so the floor applies before truncation.
    always_comb begin
        win_raw = int'(BASE_WINDOW_MS) - (int'(level) - 1) * int'(WINDOW_STEP_MS);
        if (win_raw < int'(MIN_WINDOW_MS)) window_d = WIN_W'(MIN_WINDOW_MS);
        else                               window_d = WIN_W'(win_raw);
    end

    // Datapath registers and registered output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q             <= SEC_W'(GAME_SECONDS);
            ms_q              <= '0;
            user_score        <= '0;
            level             <= LVL_W'(1);
            hit_cnt_q         <= '0;
            window_ms         <= WIN_W'(BASE_WINDOW_MS);
            game_reset        <= 1'b0;
            game_timer_enable <= 1'b0;
            game_over         <= 1'b0;
        end else begin
            sec_q             <= sec_d;
            ms_q              <= ms_d;
            user_score        <= score_d;
            level             <= level_d;
            hit_cnt_q         <= hit_cnt_d;
            window_ms         <= window_d;
            game_reset        <= (state_d == ARM);
            game_timer_enable <= (state_d == PLAY);
            game_over         <= (state_d == OVER);
        end
    end

endmodule

// File: tb/tb_game_session_controller.sv
// Directed bench for game_session_controller with a short (2 s) session.
module tb_game_session_controller;

`ifdef GAME_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, ms_tick, start_edge, hit, miss;
    logic        game_reset, game_timer_enable, game_over;
    logic [5:0]  game_timer_value;
    logic [6:0]  user_score;
    logic [3:0]  level;
    logic [10:0] window_ms;

    int compared   = 0;
    int mismatched = 0;
    int s;
    string       tag_q[$];
    logic [31:0] val_q[$];

    game_session_controller #(.GAME_SECONDS(2)) dut (
        .clk(clk), .reset(reset), .ms_tick(ms_tick), .start_edge(start_edge),
        .hit(hit), .miss(miss), .game_reset(game_reset),
        .game_timer_enable(game_timer_enable), .game_timer_value(game_timer_value),
        .user_score(user_score), .level(level), .window_ms(window_ms),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string tag, input int val);
        tag_q.push_back(tag);
        val_q.push_back(32'(val));
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        compared++;
        if (val_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_empty observed=%0d expected=none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = val_q.pop_front();
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic expect_out(input string tag, input int gr, input int en, input int tv,
                              input int sc, input int lv, input int win, input int ov);
        push({tag, ".game_reset"}, gr);
        push({tag, ".timer_enable"}, en);
        push({tag, ".timer_value"}, tv);
        push({tag, ".score"}, sc);
        push({tag, ".level"}, lv);
        push({tag, ".window"}, win);
        push({tag, ".game_over"}, ov);
    endtask

    task automatic check_out();
        check(32'(game_reset));
        check(32'(game_timer_enable));
        check(32'(game_timer_value));
        check(32'(user_score));
        check(32'(level));
        check(32'(window_ms));
        check(32'(game_over));
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            tick();
        end
        hit = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ms_tick = 1'b0; start_edge = 1'b0; hit = 1'b0; miss = 1'b0;
        @(negedge clk);
        expect_out("reset", 0, 0, 2, 0, 1, 1000, 0);
        repeat (3) tick();
        reset = 1'b0;
        check_out();

        start_edge = 1'b1;
        expect_out("arm", 1, 0, 2, 0, 1, 1000, 0);
        tick();
        start_edge = 1'b0;
        check_out();
        expect_out("play_entry", 0, 1, 2, 0, 1, 1000, 0);
        tick();
        check_out();

        start_edge = 1'b1;
        expect_out("start_in_play", 0, 1, 2, 0, 1, 1000, 0);
        tick();
        start_edge = 1'b0;
        check_out();

        expect_out("five_hits", 0, 1, 2, 5, 2, 1000, 0);
        hits(5);
        check_out();
        expect_out("window_lag", 0, 1, 2, 5, 2, 900, 0);
        tick();
        check_out();

        expect_out("level_sat", 0, 1, 2, 45, 9, 200, 0);
        hits(40);
        check_out();

        s = PEN ? 44 : 45;
        miss = 1'b1;
        expect_out("miss_at_45", 0, 1, 2, s, 9, 200, 0);
        tick();
        miss = 1'b0;
        check_out();

        s = s + 1;
        hit = 1'b1; miss = 1'b1;
        expect_out("hit_and_miss", 0, 1, 2, s, 9, 200, 0);
        tick();
        hit = 1'b0; miss = 1'b0;
        check_out();

        ms_tick = 1'b1;
        expect_out("one_second", 0, 1, 1, s, 9, 200, 0);
        repeat (1000) tick();
        check_out();
        repeat (999) tick();
        hit = 1'b1;
        expect_out("expiry_with_hit", 0, 0, 0, s + 1, 9, 200, 1);
        tick();
        check_out();
        s = s + 1;
        expect_out("hit_in_over", 0, 0, 0, s, 9, 200, 1);
        tick();
        hit = 1'b0; ms_tick = 1'b0;
        check_out();

        start_edge = 1'b1;
        expect_out("restart_arm", 1, 0, 2, 0, 1, 200, 0);
        tick();
        start_edge = 1'b0;
        check_out();
        expect_out("restart_play", 0, 1, 2, 0, 1, 1000, 0);
        tick();
        check_out();

        expect_out("three_hits", 0, 1, 2, 3, 1, 1000, 0);
        hits(3);
        check_out();
        miss = 1'b1;
        expect_out("miss_at_3", 0, 1, 2, PEN ? 2 : 3, 1, 1000, 0);
        tick();
        check_out();
        expect_out("miss_to_floor", 0, 1, 2, PEN ? 0 : 3, 1, 1000, 0);
        repeat (3) tick();
        miss = 1'b0;
        check_out();
        s = PEN ? 1 : 4;
        hit = 1'b1; miss = 1'b1;
        expect_out("hit_and_miss_2", 0, 1, 2, s, 1, 1000, 0);
        tick();
        hit = 1'b0; miss = 1'b0;
        check_out();

        expect_out("score_sat", 0, 1, 2, 99, 9, 200, 0);
        hits(105);
        check_out();

        reset = 1'b1;
        expect_out("mid_reset", 0, 0, 2, 0, 1, 1000, 0);
        tick();
        reset = 1'b0;
        check_out();
        expect_out("after_reset", 0, 0, 2, 0, 1, 1000, 0);
        tick();
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
